// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction-fetch
// requester and a data requester, with a per-transaction busy timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic        i_resp,
  output logic [31:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic        d_resp,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0] CNT_MAX  = 10'(TIMEOUT_CYCLES);

  state_t      state;
  logic        last_grant_d;
  logic [9:0]  busy_cnt;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_write;

  logic busy;
  logic timeout_hit;
  logic done;
  logic i_req;
  logic d_req;
  logic grant_d;

  always_comb begin
    busy        = (state != IDLE);
    timeout_hit = busy && !mem_resp && (busy_cnt == CNT_LAST);
    done        = busy && (mem_resp || timeout_hit);
    i_req       = i_read;
    d_req       = d_read || d_write;
    // On contention the side that did not win last time takes the port.
    grant_d     = d_req && (!i_req || !last_grant_d);
  end

  always_comb begin
    i_resp  = 1'b0;
    i_rdata = '0;
    d_resp  = 1'b0;
    d_rdata = '0;
    if (state == I_BUSY) begin
      i_resp  = done;
      i_rdata = mem_resp ? mem_rdata : '0;
    end
    if (state == D_BUSY) begin
      d_resp  = done;
      d_rdata = mem_resp ? mem_rdata : '0;
    end
  end

  always_comb begin
    mem_read        = busy && !cap_write;
    mem_write       = busy && cap_write;
    mem_byte_enable = busy ? cap_be : '0;
    mem_address     = cap_addr;
    mem_wdata       = cap_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      busy_cnt     <= '0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      cap_be       <= '0;
      cap_write    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state        <= grant_d ? D_BUSY : I_BUSY;
            last_grant_d <= grant_d;
            busy_cnt     <= '0;
            if (grant_d) begin
              // A simultaneous read+write is carried out as the write.
              cap_addr  <= d_address;
              cap_wdata <= d_wdata;
              cap_be    <= d_write ? d_byte_enable : '1;
              cap_write <= d_write;
            end else begin
              cap_addr  <= i_address;
              cap_wdata <= '0;
              cap_be    <= '1;
              cap_write <= 1'b0;
            end
          end
        end
        default: begin
          if (done) begin
            state <= IDLE;
            if (timeout_hit) timeout_err <= 1'b1;
          end else if (busy_cnt != CNT_MAX) begin
            busy_cnt <= busy_cnt + 10'd1;
          end
        end
      endcase
    end
  end

endmodule
